svcs_seg_tx: RTL and testbench

Hardware segmenting transmitter for the svcs client/server transport. Takes multi-segment transactions from up to N_CH producer channels. Each segment goes out on one shared word stream as a 4-beat header (trnx_type, trnx_id, data_type, n_payloads) followed by n_payloads payload beats. Channels are arbitrated round-robin and a granted channel keeps the stream for its whole transaction. The block sits between producer engines and the socket/DMA egress.

---
 rtl/svcs_hw_pkg.sv | 20 ++
 rtl/svcs_rr_arb.sv | 52 +++++
 rtl/svcs_seg_tx.sv | 141 ++++++++++++++
 tb/tb_svcs_seg_tx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/svcs_hw_pkg.sv
// Shared types for the svcs segmenting transmitter.
// Header layout, header beat count and FSM encoding.
package svcs_hw_pkg;

  localparam int HDR_BEATS = 4;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY
  } state_t;

  typedef struct packed {
    logic [31:0] trnx_type;
    logic [31:0] trnx_id;
    logic [31:0] data_type;
    logic [31:0] n_payloads;
  } svcs_hdr_t;

endpackage

// File: rtl/svcs_rr_arb.sv
// Round-robin arbiter with channel lock.
// Search pointer moves past a channel only when it releases.
module svcs_rr_arb #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_lock,
  input  logic [IW-1:0] i_lock_idx,
  input  logic          i_rel,
  input  logic [IW-1:0] i_rel_idx,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx
);

  logic [IW-1:0] r_ptr;
  logic          w_found;
  int            w_j;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_j       = 0;
    if (i_lock) begin
      o_gnt_idx         = i_lock_idx;
      o_gnt[i_lock_idx] = i_req[i_lock_idx];
    end else begin
      for (int i = 0; i < N; i++) begin
        w_j = int'(r_ptr) + i;
        if (w_j >= N) w_j = w_j - N;
        if (!w_found && i_req[w_j]) begin
          w_found    = 1'b1;
          o_gnt_idx  = IW'(w_j);
          o_gnt[w_j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_rel) begin
      if (i_rel_idx == IW'(N - 1)) r_ptr <= '0;
      else                         r_ptr <= i_rel_idx + 1'b1;
    end
  end

endmodule

// File: rtl/svcs_seg_tx.sv
// svcs segmenting transmitter: 4-beat header plus payload
// per segment, one locked channel per transaction.
module svcs_seg_tx
  import svcs_hw_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_CH   = 2,
  parameter int SIZE_W = 16,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH-1:0]      seg_valid,
  output logic [N_CH-1:0]      seg_ready,
  input  logic [N_CH*32-1:0]   seg_type,
  input  logic [N_CH*32-1:0]   seg_id,
  input  logic [N_CH*32-1:0]   seg_dtype,
  input  logic [N_CH*SIZE_W-1:0] seg_size,
  input  logic [N_CH-1:0]      seg_last,
  input  logic [N_CH-1:0]      pay_valid,
  output logic [N_CH-1:0]      pay_ready,
  input  logic [N_CH*DATA_W-1:0] pay_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_hdr,
  output logic                 out_last,
  output logic [CH_W-1:0]      out_ch,
  output logic                 trnx_done,
  output logic [SIZE_W-1:0]    seg_cnt
);

  state_t            r_state, w_state;
  svcs_hdr_t         r_hdr;
  logic [SIZE_W-1:0] r_size, r_cnt, r_seg_cnt;
  logic              r_last_seg, r_lock, r_done;
  logic [CH_W-1:0]   r_g, w_aidx;
  logic [N_CH-1:0]   w_agnt;
  logic [1:0]        r_hbeat;
  logic              w_take, w_fire, w_hdr_end, w_seg_end, w_rel;

  svcs_rr_arb #(.N(N_CH), .IW(CH_W)) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (seg_valid),
    .i_lock     (r_lock),
    .i_lock_idx (r_g),
    .i_rel      (w_rel),
    .i_rel_idx  (r_g),
    .o_gnt      (w_agnt),
    .o_gnt_idx  (w_aidx)
  );

  assign w_take    = (r_state == IDLE) && (|w_agnt);
  assign w_fire    = out_valid && out_ready;
  assign w_hdr_end = (r_state == HDR) && w_fire &&
                     (r_hbeat == 2'(HDR_BEATS - 1));
  assign w_seg_end = (w_hdr_end && (r_size == '0)) ||
                     ((r_state == PAY) && w_fire &&
                      (r_cnt == SIZE_W'(1)));
  assign w_rel     = w_seg_end && r_last_seg;

  always_comb begin
    w_state   = r_state;
    out_valid = 1'b0;
    out_data  = '0;
    out_hdr   = 1'b0;
    out_last  = 1'b0;
    seg_ready = '0;
    pay_ready = '0;
    unique case (r_state)
      IDLE: begin
        seg_ready = w_agnt;
        if (w_take) w_state = HDR;
      end
      HDR: begin
        out_valid = 1'b1;
        out_hdr   = 1'b1;
        out_last  = (r_hbeat == 2'(HDR_BEATS - 1)) &&
                    (r_size == '0);
        unique case (r_hbeat)
          2'd0: out_data = DATA_W'(r_hdr.trnx_type);
          2'd1: out_data = DATA_W'(r_hdr.trnx_id);
          2'd2: out_data = DATA_W'(r_hdr.data_type);
          2'd3: out_data = DATA_W'(r_hdr.n_payloads);
        endcase
        if (w_hdr_end) w_state = (r_size == '0) ? IDLE : PAY;
      end
      PAY: begin
        out_valid      = pay_valid[r_g];
        out_data       = pay_data[r_g*DATA_W +: DATA_W];
        out_last       = (r_cnt == SIZE_W'(1));
        pay_ready[r_g] = out_ready;
        if (w_seg_end) w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_hdr      <= '0;
      r_size     <= '0;
      r_cnt      <= '0;
      r_seg_cnt  <= '0;
      r_last_seg <= 1'b0;
      r_lock     <= 1'b0;
      r_done     <= 1'b0;
      r_g        <= '0;
      r_hbeat    <= '0;
    end else begin
      r_state <= w_state;
      r_done  <= w_rel;
      if (w_take) begin
        r_g        <= w_aidx;
        r_hdr      <= '{
          trnx_type:  seg_type[w_aidx*32 +: 32],
          trnx_id:    seg_id[w_aidx*32 +: 32],
          data_type:  seg_dtype[w_aidx*32 +: 32],
          n_payloads: 32'(seg_size[w_aidx*SIZE_W +: SIZE_W])
        };
        r_size     <= seg_size[w_aidx*SIZE_W +: SIZE_W];
        r_last_seg <= seg_last[w_aidx];
        r_lock     <= !seg_last[w_aidx];
        r_hbeat    <= '0;
        // a fresh transaction restarts the segment count
        if (!r_lock) r_seg_cnt <= '0;
      end
      if ((r_state == HDR) && w_fire) r_hbeat <= r_hbeat + 2'd1;
      if (w_hdr_end) r_cnt <= r_size;
      if ((r_state == PAY) && w_fire) r_cnt <= r_cnt - SIZE_W'(1);
      if (w_seg_end) r_seg_cnt <= r_seg_cnt + SIZE_W'(1);
    end
  end

  assign out_ch    = r_g;
  assign trnx_done = r_done;
  assign seg_cnt   = r_seg_cnt;

endmodule

// File: tb/tb_svcs_seg_tx.sv
// Scoreboard bench for svcs_seg_tx: producers per channel,
// expected beats queued at push time, checked on handshake.
module tb_svcs_seg_tx;

  localparam int DW = 32;
  localparam int NC = 2;
  localparam int SW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NC-1:0]   seg_valid, seg_ready, seg_last;
  logic [NC*32-1:0] seg_type, seg_id, seg_dtype;
  logic [NC*SW-1:0] seg_size;
  logic [NC-1:0]   pay_valid, pay_ready;
  logic [NC*DW-1:0] pay_data;
  logic            out_valid, out_ready, out_hdr, out_last;
  logic [DW-1:0]   out_data;
  logic [0:0]      out_ch;
  logic            trnx_done;
  logic [SW-1:0]   seg_cnt;

  always #5 clk = ~clk;

  svcs_seg_tx #(.DATA_W(DW), .N_CH(NC), .SIZE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .seg_valid(seg_valid), .seg_ready(seg_ready),
    .seg_type(seg_type), .seg_id(seg_id),
    .seg_dtype(seg_dtype), .seg_size(seg_size),
    .seg_last(seg_last),
    .pay_valid(pay_valid), .pay_ready(pay_ready),
    .pay_data(pay_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_hdr(out_hdr),
    .out_last(out_last), .out_ch(out_ch),
    .trnx_done(trnx_done), .seg_cnt(seg_cnt)
  );

  typedef struct {
    logic [31:0] t;
    logic [31:0] id;
    logic [31:0] dt;
    logic [15:0] sz;
    logic        last;
    logic [31:0] base;
  } desc_t;

  desc_t       desc_q[NC][$];
  logic [63:0] exp_q[$];
  logic [15:0] exp_done[$];
  int          seg_run[NC];
  int          checks = 0;
  int          errors = 0;
  bit          gaps = 0;
  bit          rnd_rdy = 0;
  bit          pr_seen = 0;
  int          pay_cnt = 0;
  bit          held = 0;
  logic [63:0] held_v;
  logic [63:0] cur;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int ch, input bit h,
                                     input bit l, input logic [31:0] d);
    return {24'b0, 4'(ch), 2'b0, h, l, d};
  endfunction

  task automatic push_seg(input int ch, input logic [31:0] t,
                          input logic [31:0] id, input logic [31:0] dt,
                          input logic [15:0] sz, input bit last,
                          input logic [31:0] base);
    desc_t d;
    d = '{t, id, dt, sz, last, base};
    desc_q[ch].push_back(d);
    exp_q.push_back(mk(ch, 1, 0, t));
    exp_q.push_back(mk(ch, 1, 0, id));
    exp_q.push_back(mk(ch, 1, 0, dt));
    exp_q.push_back(mk(ch, 1, sz == 0, {16'b0, sz}));
    for (int k = 0; k < int'(sz); k++)
      exp_q.push_back(mk(ch, 0, k == int'(sz) - 1, base + k));
    seg_run[ch]++;
    if (last) begin
      exp_done.push_back(16'(seg_run[ch]));
      seg_run[ch] = 0;
    end
  endtask

  for (genvar c = 0; c < NC; c++) begin : g_p
    logic        sv, pv, lst;
    logic [31:0] ty, id, dt, pd;
    logic [15:0] sz;
    assign seg_valid[c]          = sv;
    assign seg_type[c*32 +: 32]  = ty;
    assign seg_id[c*32 +: 32]    = id;
    assign seg_dtype[c*32 +: 32] = dt;
    assign seg_size[c*SW +: SW]  = sz;
    assign seg_last[c]           = lst;
    assign pay_valid[c]          = pv;
    assign pay_data[c*DW +: DW]  = pd;
    initial begin
      desc_t d;
      bit    hs;
      sv = 0; pv = 0; lst = 0;
      ty = 0; id = 0; dt = 0; pd = 0; sz = 0;
      forever begin
        @(posedge clk); #1;
        if (rst_n && desc_q[c].size() != 0) begin
          d = desc_q[c].pop_front();
          sv = 1; ty = d.t; id = d.id; dt = d.dt;
          sz = d.sz; lst = d.last;
          hs = 0;
          while (!hs && rst_n) begin
            @(negedge clk); hs = seg_ready[c];
            @(posedge clk); #1;
          end
          sv = 0;
          for (int k = 0; k < int'(d.sz) && rst_n; k++) begin
            while (gaps && $urandom_range(0, 1) == 1 && rst_n) begin
              @(posedge clk); #1;
            end
            pv = 1; pd = d.base + k;
            hs = 0;
            while (!hs && rst_n) begin
              @(negedge clk); hs = pay_ready[c];
              @(posedge clk); #1;
            end
            pv = 0;
          end
          sv = 0; pv = 0;
        end
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 0;
    end else begin
      cur = mk(int'(out_ch), out_hdr, out_last, out_data);
      if (held) begin
        chk("hdr_hold", cur, held_v);
        chk("hdr_hold_valid", 64'(out_valid), 64'd1);
      end
      if (pay_ready != '0) pr_seen = 1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0)
          chk("extra_beat", 64'(exp_q.size()), 64'd1);
        else
          chk("beat", cur, exp_q.pop_front());
        if (!out_hdr) pay_cnt++;
      end
      if (out_hdr) pay_cnt = 0;
      held   = out_valid && out_hdr && !out_ready;
      held_v = cur;
      if (trnx_done) begin
        if (exp_done.size() == 0)
          chk("extra_done", 64'(exp_done.size()), 64'd1);
        else
          chk("seg_cnt", 64'(seg_cnt), 64'(exp_done.pop_front()));
      end
    end
  end

  task automatic drain(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && exp_done.size() == 0 &&
          desc_q[0].size() == 0 && desc_q[1].size() == 0) break;
    end
    chk(tag, 64'(exp_q.size() + exp_done.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_hdr"}, 64'(out_hdr), 64'd0);
    chk({tag, "_last"}, 64'(out_last), 64'd0);
    chk({tag, "_data"}, 64'(out_data), 64'd0);
    chk({tag, "_ch"}, 64'(out_ch), 64'd0);
    chk({tag, "_seg_ready"}, 64'(seg_ready), 64'd0);
    chk({tag, "_pay_ready"}, 64'(pay_ready), 64'd0);
    chk({tag, "_done"}, 64'(trnx_done), 64'd0);
    chk({tag, "_seg_cnt"}, 64'(seg_cnt), 64'd0);
  endtask

  initial begin
    bit hit;
    seg_run[0] = 0;
    seg_run[1] = 0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;

    // single channel, size 3
    push_seg(0, 32'h11, 32'h12, 32'h13, 16'd3, 1, 32'hA000);
    drain("t1_drain");

    // empty segment: header only
    pr_seen = 0;
    push_seg(0, 32'h21, 32'h22, 32'h23, 16'd0, 1, 32'h0);
    drain("t2_drain");
    chk("t2_no_pay_ready", 64'(pr_seen), 64'd0);

    // locked 3-segment transaction while ch1 waits
    push_seg(0, 32'h31, 32'h32, 32'h33, 16'd2, 0, 32'hB000);
    push_seg(0, 32'h34, 32'h35, 32'h36, 16'd5, 0, 32'hB100);
    push_seg(0, 32'h37, 32'h38, 32'h39, 16'd1, 1, 32'hB200);
    repeat (3) @(negedge clk);
    push_seg(1, 32'h41, 32'h42, 32'h43, 16'd2, 1, 32'hC000);
    drain("t3_drain");

    // alternating single-segment transactions
    for (int i = 0; i < 3; i++) begin
      push_seg(0, 32'h50 + i, 32'h51, 32'h52, 16'd1, 1, 32'hD000 + i);
      push_seg(1, 32'h60 + i, 32'h61, 32'h62, 16'd1, 1, 32'hE000 + i);
    end
    drain("t4_drain");

    // random stalls and producer gaps
    rnd_rdy = 1; gaps = 1;
    push_seg(0, 32'h71, 32'h72, 32'h73, 16'd4, 0, 32'hF000);
    push_seg(0, 32'h74, 32'h75, 32'h76, 16'd3, 1, 32'hF100);
    push_seg(1, 32'h81, 32'h82, 32'h83, 16'd6, 1, 32'hF200);
    push_seg(0, 32'h91, 32'h92, 32'h93, 16'd2, 1, 32'hF300);
    drain("t5_drain");
    rnd_rdy = 0; gaps = 0;
    repeat (3) @(negedge clk);

    // reset in the middle of a payload
    push_seg(1, 32'hA1, 32'hA2, 32'hA3, 16'd5, 1, 32'h1000);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk); #1;
      if (out_valid && !out_hdr && pay_cnt == 2) hit = 1;
    end
    chk("t6_reach_pay2", 64'(hit), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_reset("mid_rst");
    exp_q.delete();
    exp_done.delete();
    desc_q[0].delete();
    desc_q[1].delete();
    seg_run[0] = 0;
    seg_run[1] = 0;
    repeat (3) @(negedge clk);
    push_seg(0, 32'hB1, 32'hB2, 32'hB3, 16'd1, 1, 32'h2000);
    push_seg(1, 32'hC1, 32'hC2, 32'hC3, 16'd1, 1, 32'h3000);
    @(negedge clk);
    rst_n = 1'b1;
    drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
